morse_seq_packer: RTL and testbench

Clocked, parametrised successor to the combinational sequence producer. It accumulates dot/dash symbols into a packed 2-bit-per-symbol code word, with MSB first and unused slots padded with 1s. It closes the word on a Space or EndSeq, and queues completed words in a small FIFO with a valid/ready output handshake. It sits between the signal classifier and the character decoder.

---
 rtl/morse_seq_packer_pkg.sv | 21 ++
 rtl/morse_seq_packer_if.sv | 38 +++
 rtl/morse_seq_packer_fifo.sv | 53 +++++
 rtl/morse_seq_packer.sv | 120 ++++++++++++
 tb/tb_morse_seq_packer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/morse_seq_packer_pkg.sv
// rtl/morse_seq_packer_pkg.sv - shared symbol codes, encodings and assembly FSM states
package morse_pkg;

  // Codes arriving on Signals from the signal classifier
  localparam logic [2:0] SIG_DOT    = 3'b000;
  localparam logic [2:0] SIG_DASH   = 3'b001;
  localparam logic [2:0] SIG_SPACE  = 3'b010;
  localparam logic [2:0] SIG_ENDSEQ = 3'b011;

  // Two-bit slots inside a packed code word
  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_PAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_COLLECT,
    ST_SATURATED
  } asm_state_e;

endpackage

// File: rtl/morse_seq_packer_if.sv
// rtl/morse_seq_packer_if.sv - symbol input and code-word output bundle (MORSE_SYM_COUNT_EN adds SymCount)
interface morse_seq_packer_if #(
  parameter int MAX_SYMBOLS = 5
);
  localparam int SEQ_W = 2 * MAX_SYMBOLS;

  logic [2:0]       Signals;
  logic             SignalValid;
  logic             Clear;
  logic [SEQ_W-1:0] EncSeq;
  logic             Space_EndSeqbar;
  logic             Overflow;
  logic             OutValid;
  logic             OutReady;
  logic             Dropped;
`ifdef MORSE_SYM_COUNT_EN
  localparam int CNT_W = $clog2(MAX_SYMBOLS + 1);
  logic [CNT_W-1:0] SymCount;

  modport master (
    output Signals, SignalValid, Clear, OutReady,
    input  EncSeq, Space_EndSeqbar, Overflow, OutValid, Dropped, SymCount
  );
  modport slave (
    input  Signals, SignalValid, Clear, OutReady,
    output EncSeq, Space_EndSeqbar, Overflow, OutValid, Dropped, SymCount
  );
`else
  modport master (
    output Signals, SignalValid, Clear, OutReady,
    input  EncSeq, Space_EndSeqbar, Overflow, OutValid, Dropped
  );
  modport slave (
    input  Signals, SignalValid, Clear, OutReady,
    output EncSeq, Space_EndSeqbar, Overflow, OutValid, Dropped
  );
`endif
endinterface

// File: rtl/morse_seq_packer_fifo.sv
// rtl/morse_seq_packer_fifo.sv - generic synchronous FIFO, push accepted when full if a pop happens too
module morse_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; contents are only observed when not empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/morse_seq_packer.sv
// rtl/morse_seq_packer.sv - packs dot/dash symbols into code words and queues them (MORSE_SYM_COUNT_EN adds SymCount)
module morse_seq_packer
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                Clk,
  input logic                Reset,
  morse_seq_packer_if.slave  bus
);
  localparam int SEQ_W = 2 * MAX_SYMBOLS;
  localparam int CNT_W = $clog2(MAX_SYMBOLS + 1);
`ifdef MORSE_SYM_COUNT_EN
  localparam int DW = SEQ_W + 2 + CNT_W;
`else
  localparam int DW = SEQ_W + 2;
`endif

  asm_state_e       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [SEQ_W-1:0] buf_q, buf_d;
  logic             ovf_q, ovf_d;
  logic             dropped_q;

  logic             sym_ev;
  logic             term_ev;
  logic [1:0]       sym_code;
  logic             push;
  logic [DW-1:0]    push_data;
  logic [DW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;

  assign sym_ev   = bus.SignalValid && (bus.Signals == SIG_DOT || bus.Signals == SIG_DASH);
  assign term_ev  = bus.SignalValid && (bus.Signals == SIG_SPACE || bus.Signals == SIG_ENDSEQ);
  assign sym_code = (bus.Signals == SIG_DASH) ? SYM_DASH : SYM_DOT;

  // Word as it stood before the terminator; terminator flag is 1 for Space
`ifdef MORSE_SYM_COUNT_EN
  assign push_data = {buf_q, bus.Signals == SIG_SPACE, ovf_q, idx_q};
`else
  assign push_data = {buf_q, bus.Signals == SIG_SPACE, ovf_q};
`endif

  // Assembly state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_EMPTY;
      idx_q     <= '0;
      buf_q     <= '1;
      ovf_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      ovf_q     <= ovf_d;
      dropped_q <= push && fifo_full && !bus.OutReady;
    end
  end

  // Next-state: Clear beats any input event; a terminator always restarts assembly
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    if (bus.Clear) begin
      state_d = ST_EMPTY;
      idx_d   = '0;
      buf_d   = '1;
      ovf_d   = 1'b0;
    end else if (sym_ev) begin
      if (state_q == ST_SATURATED) begin
        ovf_d = 1'b1;
      end else begin
        for (int k = 0; k < MAX_SYMBOLS; k++) begin
          if (idx_q == CNT_W'(k)) buf_d[SEQ_W-1-2*k -: 2] = sym_code;
        end
        idx_d   = idx_q + CNT_W'(1);
        state_d = (idx_q == CNT_W'(MAX_SYMBOLS - 1)) ? ST_SATURATED : ST_COLLECT;
      end
    end else if (term_ev) begin
      push    = 1'b1;
      state_d = ST_EMPTY;
      idx_d   = '0;
      buf_d   = {MAX_SYMBOLS{SYM_PAD}};
      ovf_d   = 1'b0;
    end
  end

  morse_seq_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .reset     (Reset),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.OutReady),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head outputs read idle values whenever nothing is queued
  always_comb begin
    bus.OutValid        = !fifo_empty;
    bus.EncSeq          = fifo_empty ? '1 : head[DW-1 -: SEQ_W];
    bus.Space_EndSeqbar = !fifo_empty && head[DW-1-SEQ_W];
    bus.Overflow        = !fifo_empty && head[DW-2-SEQ_W];
    bus.Dropped         = dropped_q;
`ifdef MORSE_SYM_COUNT_EN
    bus.SymCount        = fifo_empty ? '0 : head[CNT_W-1:0];
`endif
  end

endmodule

// File: tb/tb_morse_seq_packer.sv
// tb/tb_morse_seq_packer.sv - directed self-checking bench for morse_seq_packer
module tb_morse_seq_packer;
  import morse_pkg::*;

  localparam int MAX_SYMBOLS = 5;
  localparam int FIFO_DEPTH  = 4;

  logic Clk;
  logic Reset;
  int   n_tests;
  int   n_fail;

  morse_seq_packer_if #(.MAX_SYMBOLS(MAX_SYMBOLS)) bus ();

  morse_seq_packer #(
    .MAX_SYMBOLS (MAX_SYMBOLS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] code);
    @(negedge Clk);
    bus.Signals     = code;
    bus.SignalValid = 1'b1;
    @(posedge Clk);
    #1;
    bus.SignalValid = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge Clk);
    bus.OutReady = 1'b1;
    @(posedge Clk);
    #1;
    bus.OutReady = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [9:0] seq, input logic sp,
                          input logic ovf, input int cnt);
    check({tag, ".valid"}, 32'(bus.OutValid), 32'd1);
    check({tag, ".seq"},   32'(bus.EncSeq), 32'(seq));
    check({tag, ".sp"},    32'(bus.Space_EndSeqbar), 32'(sp));
    check({tag, ".ovf"},   32'(bus.Overflow), 32'(ovf));
`ifdef MORSE_SYM_COUNT_EN
    check({tag, ".cnt"},   32'(bus.SymCount), 32'(cnt));
`endif
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".valid"}, 32'(bus.OutValid), 32'd0);
    check({tag, ".seq"},   32'(bus.EncSeq), 32'h3FF);
    check({tag, ".sp"},    32'(bus.Space_EndSeqbar), 32'd0);
    check({tag, ".ovf"},   32'(bus.Overflow), 32'd0);
`ifdef MORSE_SYM_COUNT_EN
    check({tag, ".cnt"},   32'(bus.SymCount), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_seq [4];
    logic       exp_sp  [4];
    int         exp_cnt [4];

    n_tests = 0;
    n_fail  = 0;
    Reset           = 1'b1;
    bus.Signals     = 3'b000;
    bus.SignalValid = 1'b0;
    bus.Clear       = 1'b0;
    bus.OutReady    = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk_idle("reset");
    check("reset.drop", 32'(bus.Dropped), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // 1: dot, dash, dot (with ignored 1xx codes between) then EndSeq
    bus.OutReady = 1'b1;
    send(SIG_DOT);
    send(3'b100);
    send(SIG_DASH);
    send(3'b111);
    send(SIG_DOT);
    check("t1.pre", 32'(bus.OutValid), 32'd0);
    send(SIG_ENDSEQ);
    chk_head("t1", 10'b00_01_00_11_11, 1'b0, 1'b0, 3);
    @(posedge Clk); #1;
    chk_idle("t1.popped");

    // 2: seven dashes then Space saturate and flag overflow
    for (int i = 0; i < 7; i++) send(SIG_DASH);
    send(SIG_SPACE);
    chk_head("t2", 10'b01_01_01_01_01, 1'b1, 1'b1, 5);
    @(posedge Clk); #1;
    chk_idle("t2.popped");

    // exactly MAX_SYMBOLS symbols is not an overflow; bare gap is all pads
    for (int i = 0; i < 5; i++) send(SIG_DOT);
    send(SIG_ENDSEQ);
    chk_head("full5", 10'b00_00_00_00_00, 1'b0, 1'b0, 5);
    send(SIG_SPACE);
    chk_head("gap", 10'h3FF, 1'b1, 1'b0, 0);
    @(posedge Clk); #1;
    chk_idle("gap.popped");

    // 3: five words against a stalled consumer; the fifth is dropped
    @(negedge Clk);
    bus.OutReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(SIG_DOT);
      send(SIG_SPACE);
      check($sformatf("t3.drop%0d", i), 32'(bus.Dropped), (i == 4) ? 32'd1 : 32'd0);
    end
    @(posedge Clk); #1;
    check("t3.drop_end", 32'(bus.Dropped), 32'd0);
    chk_head("t3.hold0", 10'b00_11_11_11_11, 1'b1, 1'b0, 1);
    repeat (3) @(posedge Clk);
    #1;
    chk_head("t3.hold1", 10'b00_11_11_11_11, 1'b1, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("t3.drain%0d", i), 10'b00_11_11_11_11, 1'b1, 1'b0, 1);
      pop_one();
    end
    chk_idle("t3.empty");

    // 4: full queue, pop and push on the same edge
    exp_seq[0] = 10'b00_11_11_11_11; exp_sp[0] = 1'b1; exp_cnt[0] = 1;
    exp_seq[1] = 10'b01_11_11_11_11; exp_sp[1] = 1'b1; exp_cnt[1] = 1;
    exp_seq[2] = 10'b00_00_11_11_11; exp_sp[2] = 1'b0; exp_cnt[2] = 2;
    exp_seq[3] = 10'b01_00_11_11_11; exp_sp[3] = 1'b1; exp_cnt[3] = 2;
    send(SIG_DOT);  send(SIG_SPACE);
    send(SIG_DASH); send(SIG_SPACE);
    send(SIG_DOT);  send(SIG_DOT);  send(SIG_ENDSEQ);
    send(SIG_DASH); send(SIG_DOT);  send(SIG_SPACE);
    chk_head("t4.head", exp_seq[0], exp_sp[0], 1'b0, exp_cnt[0]);
    send(SIG_DASH);
    send(SIG_DASH);
    @(negedge Clk);
    bus.OutReady    = 1'b1;
    bus.Signals     = SIG_ENDSEQ;
    bus.SignalValid = 1'b1;
    @(posedge Clk); #1;
    bus.OutReady    = 1'b0;
    bus.SignalValid = 1'b0;
    check("t4.nodrop", 32'(bus.Dropped), 32'd0);
    // queue should still be full: one more word must be dropped
    send(SIG_DOT);
    send(SIG_SPACE);
    check("t4.stillfull", 32'(bus.Dropped), 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk_head($sformatf("t4.drain%0d", i), exp_seq[i], exp_sp[i], 1'b0, exp_cnt[i]);
      pop_one();
    end
    chk_head("t4.last", 10'b01_01_11_11_11, 1'b0, 1'b0, 2);
    pop_one();
    chk_idle("t4.empty");

    // 5: Clear together with a dot discards the partial word only
    send(SIG_DASH);
    send(SIG_ENDSEQ);
    send(SIG_DASH);
    send(SIG_DASH);
    @(negedge Clk);
    bus.Clear       = 1'b1;
    bus.Signals     = SIG_DOT;
    bus.SignalValid = 1'b1;
    @(posedge Clk); #1;
    bus.Clear       = 1'b0;
    bus.SignalValid = 1'b0;
    chk_head("t5.kept", 10'b01_11_11_11_11, 1'b0, 1'b0, 1);
    send(SIG_DOT);
    send(SIG_ENDSEQ);
    pop_one();
    chk_head("t5.word", 10'b00_11_11_11_11, 1'b0, 1'b0, 1);
    pop_one();
    chk_idle("t5.empty");

    // 6: Reset mid-word with two words queued
    send(SIG_DOT);
    send(SIG_SPACE);
    send(SIG_DASH);
    send(SIG_ENDSEQ);
    send(SIG_DASH);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk_idle("t6.reset");
    check("t6.drop", 32'(bus.Dropped), 32'd0);
    send(SIG_DASH);
    send(SIG_ENDSEQ);
    chk_head("t6.word", 10'b01_11_11_11_11, 1'b0, 1'b0, 1);
    pop_one();
    chk_idle("t6.empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
